// File: rtl/case_6_pkg.sv
// Shared types and constants for the case_6 accumulation stage.
// Build option: define CASE_6_ACC_SAT_EN to saturate the accumulator
// instead of wrapping it.
package case_6_pkg;

   // Default operand widths of the case_6 datapath.
   localparam int DIN_WIDTH = 22;
   localparam int ACC_WIDTH = 26;

   // Saturation rails for the accumulator.
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   // Group accumulation FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage : case_6_pkg

// File: rtl/case_6_sat_add.sv
// Combinational sign-extend-and-add for the accumulator.
// Build option: CASE_6_ACC_SAT_EN clamps each sum to [ACC_MIN, ACC_MAX];
// without it the sum wraps modulo 2^ACC_WIDTH.
// The rails come from case_6_pkg, so saturation assumes the package width.
module case_6_sat_add
   import case_6_pkg::*;
#(
   parameter int DIN_W = DIN_WIDTH,
   parameter int ACC_W = ACC_WIDTH
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [DIN_W-1:0] din,
   output logic signed [ACC_W-1:0] sum
);

   logic signed [ACC_W-1:0] din_ext;
   logic signed [ACC_W-1:0] raw;

   // Sign-extend the product and add it to the running sum.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
      sum     = '0;
      din_ext = ACC_W'(din);
      raw     = acc + din_ext;
`ifdef CASE_6_ACC_SAT_EN
      // Overflow only when both operands share a sign the result does not.
      if ((acc[ACC_W-1] == din_ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1])) begin
         sum = acc[ACC_W-1] ? ACC_W'(ACC_MIN) : ACC_W'(ACC_MAX);
      end else begin
         sum = raw;
      end
`else
      sum = raw;
`endif
   end

endmodule : case_6_sat_add

// File: rtl/case_6_acc_22s_26s.sv
// Accumulation stage for the signed 22-bit product stream: sums up to LEN
// products per group and presents each group sum on a registered
// valid/ready port. A group closes on din_last or after LEN products.
// Build option: CASE_6_ACC_SAT_EN selects saturating instead of wrapping adds.
module case_6_acc_22s_26s
   import case_6_pkg::*;
#(
   parameter int DIN_WIDTH = case_6_pkg::DIN_WIDTH,
   parameter int ACC_WIDTH = case_6_pkg::ACC_WIDTH,
   parameter int LEN       = 16,
   parameter int CNT_WIDTH = 11
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic                        clr,
   input  logic signed [DIN_WIDTH-1:0] din,
   input  logic                        din_last,
   input  logic                        din_vld,
   output logic                        din_rdy,
   output logic signed [ACC_WIDTH-1:0] dout,
   output logic [CNT_WIDTH-1:0]        dout_cnt,
   output logic                        dout_vld,
   input  logic                        dout_rdy
);

   state_t                      state;
   logic signed [ACC_WIDTH-1:0] acc;
   logic [CNT_WIDTH-1:0]        cnt;

   logic                        accept;
   logic signed [ACC_WIDTH-1:0] add_base;
   logic signed [ACC_WIDTH-1:0] sum;
   logic [CNT_WIDTH-1:0]        cnt_nxt;
   logic                        closing;

   // Upstream may only push while no result is waiting.
   assign din_rdy = (state != HOLD);
   assign accept  = din_vld && din_rdy;

   // A group's first product starts from zero rather than the stale sum.
   always_comb begin
      add_base = '0;
      cnt_nxt  = CNT_WIDTH'(1);
      if (state == ACCUM) begin
         add_base = acc;
         cnt_nxt  = cnt + CNT_WIDTH'(1);
      end
   end

   assign closing = din_last || (cnt_nxt == CNT_WIDTH'(LEN));

   case_6_sat_add #(
      .DIN_W (DIN_WIDTH),
      .ACC_W (ACC_WIDTH)
   ) u_add (
      .acc (add_base),
      .din (din),
      .sum (sum)
   );

   // Group FSM, running sum, term counter and registered result port.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      // NOTE: state is assigned with <= so every register samples pre-edge values.
      if (!ap_rst_n) begin
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         dout     <= '0;
         dout_cnt <= '0;
         dout_vld <= 1'b0;
      end else if (clr) begin
         // Abandon any partial group or pending result.
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         dout_vld <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc <= sum;
                  cnt <= cnt_nxt;
                  if (closing) begin
                     state    <= HOLD;
                     dout     <= sum;
                     dout_cnt <= cnt_nxt;
                     dout_vld <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (dout_vld && dout_rdy) begin
                  state    <= IDLE;
                  dout_vld <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               dout_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule : case_6_acc_22s_26s

// File: tb/tb_case_6_acc_22s_26s.sv
// Self-checking bench for case_6_acc_22s_26s. Instance 0 uses LEN=4,
// instance 1 uses LEN=64. Honours CASE_6_ACC_SAT_EN for expectations.
module tb_case_6_acc_22s_26s;

   localparam longint MOD  = 64'sd1 <<< 26;
   localparam longint HALF = 64'sd1 <<< 25;

   logic clk = 1'b0;
   logic rst_n;

   logic                clr      [2];
   logic signed [21:0]  din      [2];
   logic                din_last [2];
   logic                din_vld  [2];
   logic                din_rdy  [2];
   logic signed [25:0]  dout     [2];
   logic [10:0]         dout_cnt [2];
   logic                dout_vld [2];
   logic                dout_rdy [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   case_6_acc_22s_26s #(.LEN(4)) u_len4 (
      .ap_clk(clk), .ap_rst_n(rst_n), .clr(clr[0]),
      .din(din[0]), .din_last(din_last[0]), .din_vld(din_vld[0]), .din_rdy(din_rdy[0]),
      .dout(dout[0]), .dout_cnt(dout_cnt[0]), .dout_vld(dout_vld[0]), .dout_rdy(dout_rdy[0])
   );

   case_6_acc_22s_26s #(.LEN(64)) u_len64 (
      .ap_clk(clk), .ap_rst_n(rst_n), .clr(clr[1]),
      .din(din[1]), .din_last(din_last[1]), .din_vld(din_vld[1]), .din_rdy(din_rdy[1]),
      .dout(dout[1]), .dout_cnt(dout_cnt[1]), .dout_vld(dout_vld[1]), .dout_rdy(dout_rdy[1])
   );

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: group sum from plain integer arithmetic.
   function automatic longint model_sum(input longint q[$]);
      longint a = 0;
`ifdef CASE_6_ACC_SAT_EN
      foreach (q[i]) begin
         a = a + q[i];
         if (a > HALF - 1) a = HALF - 1;
         else if (a < -HALF) a = -HALF;
      end
`else
      foreach (q[i]) a = a + q[i];
      a = ((a % MOD) + MOD) % MOD;
      if (a >= HALF) a = a - MOD;
`endif
      return a;
   endfunction

   // Offer one beat at a falling edge; returns one falling edge after acceptance.
   task automatic send(input int s, input longint d, input bit last);
      int guard = 0;
      while (din_rdy[s] !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check("send_rdy_timeout", din_rdy[s], 1);
      din[s]      = 22'(d);
      din_last[s] = last;
      din_vld[s]  = 1'b1;
      @(negedge clk);
      din_vld[s]  = 1'b0;
      din_last[s] = 1'b0;
   endtask

   // Release a held result and confirm it drops.
   task automatic drain(input int s, input string tag);
      dout_rdy[s] = 1'b1;
      @(negedge clk);
      dout_rdy[s] = 1'b0;
      check({tag, "_vld_drop"}, dout_vld[s], 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      longint q[$];
      longint exp_sum;
      logic signed [21:0] r;
      int lastp;
      bit last;

      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         clr[s] = 1'b0; din[s] = '0; din_last[s] = 1'b0;
         din_vld[s] = 1'b0; dout_rdy[s] = 1'b0;
      end

      // Reset: three cycles low, values must also hold after release.
      repeat (3) @(negedge clk);
      check("rst_dout", dout[0], 0);
      check("rst_cnt", dout_cnt[0], 0);
      check("rst_vld", dout_vld[0], 0);
      check("rst_rdy", din_rdy[0], 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_vld", dout_vld[1], 0);
      check("post_rst_rdy", din_rdy[1], 1);
      check("post_rst_dout", dout[1], 0);

      // Basic group closed by count (LEN=4), downstream always ready.
      dout_rdy[0] = 1'b1;
      send(0, 3, 0); send(0, -5, 0); send(0, 100, 0); send(0, -2, 0);
      check("basic_vld", dout_vld[0], 1);
      check("basic_dout", dout[0], 96);
      check("basic_cnt", dout_cnt[0], 4);
      check("basic_rdy_hold", din_rdy[0], 0);
      @(negedge clk);
      check("basic_vld_one_cycle", dout_vld[0], 0);
      check("basic_rdy_back", din_rdy[0], 1);
      dout_rdy[0] = 1'b0;

      // Early close with five cycles of backpressure.
      send(0, 7, 0); send(0, -9, 1);
      for (int i = 0; i < 5; i++) begin
         check("bp_vld", dout_vld[0], 1);
         check("bp_dout", dout[0], -2);
         check("bp_cnt", dout_cnt[0], 2);
         check("bp_rdy", din_rdy[0], 0);
         @(negedge clk);
      end
      drain(0, "bp");

      // Overflow: 40 x 2^20 on the LEN=64 instance.
      for (int i = 0; i < 40; i++) send(1, 1048576, i == 39);
`ifdef CASE_6_ACC_SAT_EN
      check("ovf_dout", dout[1], 33554431);
`else
      check("ovf_dout", dout[1], -25165824);
`endif
      check("ovf_cnt", dout_cnt[1], 40);
      check("ovf_vld", dout_vld[1], 1);
      drain(1, "ovf");

      // Mid-group clear together with an offered beat.
      send(0, 11, 0); send(0, 22, 0);
      clr[0] = 1'b1; din[0] = 22'sd50; din_vld[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0; din_vld[0] = 1'b0;
      check("clr_vld", dout_vld[0], 0);
      check("clr_rdy", din_rdy[0], 1);
      send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 0);
      check("clr_next_dout", dout[0], 10);
      check("clr_next_cnt", dout_cnt[0], 4);
      check("clr_next_vld", dout_vld[0], 1);
      drain(0, "clr");

      // Randomized groups on LEN=64 against the reference sum.
      for (int g = 0; g < 14; g++) begin
         q.delete();
         lastp = $urandom_range(3, 90);
         do begin
            r = 22'($urandom);
            q.push_back(longint'(r));
            last = ($urandom_range(0, lastp - 1) == 0);
            send(1, longint'(r), last);
         end while (!last && q.size() < 64);
         exp_sum = model_sum(q);
         check("rnd_vld", dout_vld[1], 1);
         check("rnd_dout", dout[1], exp_sum);
         check("rnd_cnt", dout_cnt[1], q.size());
         repeat ($urandom_range(0, 3)) @(negedge clk);
         check("rnd_dout_stable", dout[1], exp_sum);
         drain(1, "rnd");
      end

      // Asynchronous reset asserted mid-cycle while holding a result.
      send(0, 5, 0); send(0, 6, 1);
      check("arst_pre_vld", dout_vld[0], 1);
      check("arst_pre_dout", dout[0], 11);
      #2 rst_n = 1'b0;
      #1;
      check("arst_vld", dout_vld[0], 0);
      check("arst_rdy", din_rdy[0], 1);
      check("arst_dout", dout[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_idle_rdy", din_rdy[0], 1);
      check("arst_idle_vld", dout_vld[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_case_6_acc_22s_26s

// File: doc/case_6_acc_22s_26s.md
# case_6_acc_22s_26s

Downstream accumulation stage for the signed 12s×10s→22s product stream of the case_6 datapath. It consumes one 22-bit signed product per accepted beat and sums up to LEN products into a signed accumulator. It presents each completed sum on a registered valid/ready output port. A group closes when LEN products have been accepted or when the upstream marks the final beat.

## Interface
- DIN_WIDTH, 22: signed product width from the multiplier.
- ACC_WIDTH, 26: signed accumulator and result width; must be ≥ DIN_WIDTH.
- LEN, 16: maximum products per group; 2..1024.
- CNT_WIDTH, 11: term-count width; must satisfy 2^CNT_WIDTH > LEN.

- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear, active-high.
- din  in  DIN_WIDTH  signed product.
- din_last  in  1  marks the final product of a group.
- din_vld  in  1  product valid.
- din_rdy  out  1  stage can accept a product.
- dout  out  ACC_WIDTH  signed group sum.
- dout_cnt  out  CNT_WIDTH  number of products in the group.
- dout_vld  out  1  result valid.
- dout_rdy  in  1  downstream accepts the result.

## Operation
- States: IDLE, ACCUM, HOLD.
- A beat is accepted when din_vld && din_rdy. din_rdy = (state != HOLD), decoded combinationally from the state register.
- IDLE, on an accepted beat:
  - acc ← sext(din); cnt ← 1.
  - Go to ACCUM, or to HOLD if din_last.
- ACCUM, on an accepted beat:
  - acc ← acc + sext(din); cnt ← cnt + 1.
  - Go to HOLD if din_last or if the new cnt equals LEN.
- Entering HOLD loads dout/dout_cnt from the updated acc/cnt and sets dout_vld.
- HOLD: dout, dout_cnt and dout_vld stay stable until dout_vld && dout_rdy. That handshake clears dout_vld and returns to IDLE.
- A din beat offered in the same cycle as the HOLD handshake is not accepted, because din_rdy = 0 in HOLD.
- Arithmetic: two's complement; din is sign-extended to ACC_WIDTH before the add. Overflow behaviour is set by the configuration macro.
- clr: in any state, forces IDLE, acc = 0, cnt = 0, dout_vld = 0. It overrides a simultaneous accepted beat and a simultaneous output handshake.
- A clr or ap_rst_n assertion mid-group discards the partial sum. No result is emitted for that group.

## Timing
- Reset values: dout = 0, dout_cnt = 0, dout_vld = 0, state = IDLE, so din_rdy = 1.
- Latency: dout_vld rises on the edge that accepts the closing beat. The result is visible in the following cycle, with no combinational din→dout path.
- Throughput: one product per cycle inside a group, plus one bubble cycle per group (the HOLD cycle), extended by any backpressure.
- dout_rdy may be asserted before dout_vld; the handshake completes in the first cycle where both are high.

## Configuration
- CASE_6_ACC_SAT_EN defined: each add saturates to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. Once saturated, later adds of the opposite sign move the value off the rail normally.
- Not defined: the add wraps modulo 2^ACC_WIDTH.
- dout_cnt is unaffected by the macro.

## Structure
- Shared package case_6_pkg holds:
  - the state enum (IDLE/ACCUM/HOLD);
  - DIN_WIDTH/ACC_WIDTH defaults;
  - the ACC_MAX/ACC_MIN constants used by saturation.
- One sub-module, case_6_sat_add: a combinational sign-extend-and-add, with saturation under CASE_6_ACC_SAT_EN.
- The FSM, counter and output register stay in the top block.

## Test plan
- Reset check:
  - Stimulus: hold ap_rst_n low for 3 cycles.
  - Response: dout = 0, dout_cnt = 0, dout_vld = 0, din_rdy = 1; all hold after release.
- Basic group:
  - Stimulus: LEN = 4; back-to-back din = 3, −5, 100, −2; dout_rdy = 1.
  - Response: dout = 96, dout_cnt = 4; dout_vld is high for exactly one cycle; din_rdy is low during HOLD.
- Early close and backpressure:
  - Stimulus: din = 7, −9, with din_last on −9; dout_rdy held low for 5 cycles.
  - Response: dout = −2, dout_cnt = 2; output stable for all 5 cycles; din_rdy = 0 throughout.
- Overflow:
  - Stimulus: LEN = 64; 40 beats of din = 1048576, the last with din_last.
  - Response with CASE_6_ACC_SAT_EN: dout = 33554431.
  - Response without: dout = −25165824.
  - Both builds: dout_cnt = 40.
- Mid-group clear:
  - Stimulus: after 2 of 4 beats, pulse clr together with an offered beat din = 50; then send 1, 2, 3, 4.
  - Response: the beat with clr is ignored; no output for the aborted group; next result dout = 10, dout_cnt = 4.
- Asynchronous reset:
  - Stimulus: assert ap_rst_n in HOLD, mid-cycle.
  - Response: dout_vld drops immediately, without waiting for a clock edge; state returns to IDLE.
